ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/cpu_types_pkg.sv | 30 +++
 rtl/arb_timer.sv | 41 ++++
 rtl/ram_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU types used by the RAM arbiter and its timeout timer.
//   word_t      : 32-bit data/address word
//   ramstate_t  : RAM handshake state (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t : arbiter FSM state (IDLE, DATA, INSTR, HALTED)
//   WAIT_W      : width of the transaction wait counter
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int WAIT_W = 5;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        INSTR  = 2'd2,
        HALTED = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_timer.sv
// -----------------------------------------------------------------------------
// arb_timer
// Wait counter for a granted RAM transaction. Cleared when a transaction is
// granted, advanced on every cycle the RAM has not answered with ACCESS, and
// flags expiry once TIMEOUT-1 non-ACCESS cycles have been counted.
// Ports:
//   CLK     in  : rising-edge clock
//   nRST    in  : asynchronous active-low reset
//   clear   in  : restart the count (transaction granted)
//   tick    in  : one more cycle waited without ACCESS
//   expired out : count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module arb_timer
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    logic [WAIT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= r_count + WAIT_W'(1);
        end
    end

    assign expired = (r_count == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Arbitrates a single-ported RAM between an instruction fetch port and a data
// port. Data requests normally win; an instruction request that has been
// passed over STARVE_MAX times in a row is granted next. Each grant lasts until
// the RAM reports ACCESS (hit), ERROR or a timeout (err pulse), or until the
// owning request drops. A halt request parks the arbiter in HALTED for good.
//
// Parameters:
//   TIMEOUT    : max cycles a granted transaction waits for ACCESS
//   STARVE_MAX : consecutive data grants allowed while iREN waits
// Ports:
//   CLK, nRST                 : clock, asynchronous active-low reset
//   iREN, iaddr, iload, ihit  : instruction fetch port
//   dREN, dWEN, daddr, dstore,
//   dload, dhit               : data port
//   halt, halted              : pipeline halt request / arbiter quiesced
//   ramREN, ramWEN, ramaddr,
//   ramstore, ramload,
//   ramstate                  : RAM side
//   err                       : one-cycle pulse on timeout or RAM ERROR
// Optional build macro ARB_PERF_CNT_EN adds icycles_wait / dcycles_wait,
// saturating counts of cycles each request is high without its hit.
// -----------------------------------------------------------------------------
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  word_t       iaddr,
    output word_t       iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  word_t       daddr,
    input  word_t       dstore,
    output word_t       dload,
    output logic        dhit,
    input  logic        halt,
    output logic        halted,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  logic [1:0]  ramstate,
    output logic        err
`ifdef ARB_PERF_CNT_EN
    ,
    output word_t       icycles_wait,
    output word_t       dcycles_wait
`endif
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    arb_state_t  r_state;
    logic [SW-1:0] r_starve;

    ramstate_t   w_ramstate;
    logic        w_d_req;
    logic        w_access;
    logic        w_error;
    logic        w_expired;
    logic        w_in_data;
    logic        w_in_instr;
    logic        w_starved;
    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_tick;
    logic        w_d_end;
    logic        w_i_end;

    assign w_ramstate = ramstate_t'(ramstate);
    assign w_access   = (w_ramstate == ACCESS);
    assign w_error    = (w_ramstate == ERROR);
    assign w_d_req    = dREN | dWEN;
    assign w_in_data  = (r_state == DATA);
    assign w_in_instr = (r_state == INSTR);

    // Starvation override only matters when an instruction fetch is waiting.
    assign w_starved = (r_starve == SW'(STARVE_MAX)) && iREN;
    assign w_grant_i = (r_state == IDLE) && !halt && iREN && (w_starved || !w_d_req);
    assign w_grant_d = (r_state == IDLE) && !halt && w_d_req && !w_starved;

    assign w_tick = (w_in_data || w_in_instr) && !w_access;

    // A transaction ends on ACCESS, ERROR, timeout, or loss of its request.
    assign w_d_end = w_in_data  && (!w_d_req || w_access || w_error || w_expired);
    assign w_i_end = w_in_instr && (!iREN    || w_access || w_error || w_expired);

    arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (w_grant_d | w_grant_i),
        .tick    (w_tick),
        .expired (w_expired)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_starve <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (halt) begin
                        r_state <= HALTED;
                    end else if (w_grant_i) begin
                        r_state  <= INSTR;
                        r_starve <= '0;
                    end else if (w_grant_d) begin
                        r_state <= DATA;
                        if (iREN && (r_starve != SW'(STARVE_MAX)))
                            r_starve <= r_starve + SW'(1);
                    end
                end
                DATA:    if (w_d_end) r_state <= IDLE;
                INSTR:   if (w_i_end) r_state <= IDLE;
                HALTED:  r_state <= HALTED;
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        dload    = '0;
        iload    = '0;
        dhit     = 1'b0;
        ihit     = 1'b0;
        err      = 1'b0;
        case (r_state)
            DATA: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;   // write wins when both are raised
                dload    = ramload;
                dhit     = w_d_req && w_access;
                err      = w_d_req && !w_access && (w_error || w_expired);
            end
            INSTR: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                iload   = ramload;
                ihit    = iREN && w_access;
                err     = iREN && !w_access && (w_error || w_expired);
            end
            default: ;
        endcase
    end

    assign halted = (r_state == HALTED);

`ifdef ARB_PERF_CNT_EN
    word_t r_icycles_wait;
    word_t r_dcycles_wait;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_icycles_wait <= '0;
            r_dcycles_wait <= '0;
        end else begin
            if (iREN && !ihit && (r_icycles_wait != '1))
                r_icycles_wait <= r_icycles_wait + 32'd1;
            if (w_d_req && !dhit && (r_dcycles_wait != '1))
                r_dcycles_wait <= r_dcycles_wait + 32'd1;
        end
    end

    assign icycles_wait = r_icycles_wait;
    assign dcycles_wait = r_dcycles_wait;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
// Directed bench for ram_arbiter. Inputs are driven 1 ns after the rising edge
// and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        ihit;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dhit;
    logic        halt;
    logic        halted;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] icycles_wait;
    logic [31:0] dcycles_wait;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    ram_arbiter dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .ihit     (ihit),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dhit     (dhit),
        .halt     (halt),
        .halted   (halted),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .err      (err)
`ifdef ARB_PERF_CNT_EN
        ,
        .icycles_wait (icycles_wait),
        .dcycles_wait (dcycles_wait)
`endif
    );

    task automatic drive_idle();
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        iaddr    = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = RS_FREE;
        halt     = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Reset holds every output at 0 even with requests raised.
    task automatic test_reset();
        nRST  = 1'b0;
        drive_idle();
        iREN  = 1'b1;
        dREN  = 1'b1;
        dWEN  = 1'b1;
        daddr = 32'h55;
        ramstate = RS_ACCESS;
        @(negedge CLK);
        n_checks++;
        if ({ramREN, ramWEN, ihit, dhit, err, halted} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000", {ramREN, ramWEN, ihit, dhit, err, halted});
        end
        n_checks++;
        if ({ramaddr, ramstore} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr %h store %h want 0", ramaddr, ramstore);
        end
        drive_idle();
        nRST = 1'b1;
        next_cycle();
    endtask

    // Instruction fetch: one IDLE arbitration cycle, then hit on ACCESS.
    task automatic test_instr_fetch();
        iREN     = 1'b1;
        iaddr    = 32'h40;
        ramstate = RS_BUSY;
        @(negedge CLK);
        n_checks++;
        if ({ramREN, ihit} !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_arb_cycle: got ramREN/ihit %b want 00", {ramREN, ihit});
        end
        next_cycle();
        ramstate = RS_ACCESS;
        ramload  = 32'h8C01_0004;
        @(negedge CLK);
        n_checks++;
        if (ihit !== 1'b1 || dhit !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_hit: got ihit %b dhit %b want 1 0", ihit, dhit);
        end
        n_checks++;
        if (iload !== 32'h8C01_0004) begin
            n_fail++;
            $display("FAIL fetch_iload: got %h want 8c010004", iload);
        end
        n_checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin
            n_fail++;
            $display("FAIL fetch_ram: got ramREN %b ramaddr %h want 1 00000040", ramREN, ramaddr);
        end
        next_cycle();
        drive_idle();
        @(negedge CLK);
        n_checks++;
        if ({ramREN, ihit} !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_back_idle: got ramREN/ihit %b want 00", {ramREN, ihit});
        end
        next_cycle();
    endtask

    // Data wins simultaneous arbitration; write wins over read.
    task automatic test_data_priority();
        iREN     = 1'b1;
        iaddr    = 32'h40;
        dREN     = 1'b1;
        dWEN     = 1'b1;
        daddr    = 32'h100;
        dstore   = 32'hDEAD;
        ramstate = RS_BUSY;
        next_cycle();
        ramstate = RS_ACCESS;
        ramload  = 32'h0BAD_F00D;
        @(negedge CLK);
        n_checks++;
        if (dhit !== 1'b1 || ihit !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_dhit: got dhit %b ihit %b want 1 0", dhit, ihit);
        end
        n_checks++;
        if ({ramWEN, ramREN} !== 2'b10) begin
            n_fail++;
            $display("FAIL prio_wen: got ramWEN/ramREN %b want 10", {ramWEN, ramREN});
        end
        n_checks++;
        if (ramstore !== 32'hDEAD || ramaddr !== 32'h100) begin
            n_fail++;
            $display("FAIL prio_bus: got store %h addr %h want 0000dead 00000100", ramstore, ramaddr);
        end
        next_cycle();
        dREN     = 1'b0;
        dWEN     = 1'b0;
        ramstate = RS_BUSY;
        @(negedge CLK);
        n_checks++;
        if ({ramREN, ramWEN} !== 2'b00) begin
            n_fail++;
            $display("FAIL prio_idle: got ramREN/ramWEN %b want 00", {ramREN, ramWEN});
        end
        next_cycle();
        ramstate = RS_ACCESS;
        ramload  = 32'h1111_2222;
        @(negedge CLK);
        n_checks++;
        if (ihit !== 1'b1 || ramREN !== 1'b1 || ramaddr !== 32'h40) begin
            n_fail++;
            $display("FAIL prio_instr_next: got ihit %b ramREN %b addr %h want 1 1 00000040", ihit, ramREN, ramaddr);
        end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    // Four data grants, then the waiting fetch must win.
    task automatic test_starvation();
        iREN     = 1'b1;
        iaddr    = 32'h80;
        dREN     = 1'b1;
        daddr    = 32'h200;
        ramstate = RS_ACCESS;
        ramload  = 32'h1234_5678;
        for (int g = 1; g <= 5; g++) begin
            next_cycle();
            @(negedge CLK);
            n_checks++;
            if (g < 5) begin
                if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'h1234_5678) begin
                    n_fail++;
                    $display("FAIL starve_grant%0d: got dhit %b ihit %b dload %h want 1 0 12345678", g, dhit, ihit, dload);
                end
            end else begin
                if (ihit !== 1'b1 || dhit !== 1'b0 || iload !== 32'h1234_5678) begin
                    n_fail++;
                    $display("FAIL starve_grant%0d: got ihit %b dhit %b iload %h want 1 0 12345678", g, ihit, dhit, iload);
                end
            end
            next_cycle();
        end
        drive_idle();
        next_cycle();
    endtask

    // BUSY for TIMEOUT cycles: err on the 16th, never a hit.
    task automatic test_timeout();
        dREN     = 1'b1;
        daddr    = 32'h300;
        ramstate = RS_BUSY;
        next_cycle();
        for (int c = 1; c <= 16; c++) begin
            @(negedge CLK);
            n_checks++;
            if (err !== (c == 16) || dhit !== 1'b0 || ramREN !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_cyc%0d: got err %b dhit %b ramREN %b want %b 0 1", c, err, dhit, ramREN, (c == 16));
            end
            next_cycle();
        end
        dREN = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({err, ramREN} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_idle: got err/ramREN %b want 00", {err, ramREN});
        end
        drive_idle();
        next_cycle();
    endtask

    // RAM ERROR pulses err; dropping the request aborts quietly.
    task automatic test_error_abort();
        dWEN     = 1'b1;
        daddr    = 32'h4;
        ramstate = RS_ERROR;
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (err !== 1'b1 || dhit !== 1'b0) begin
            n_fail++;
            $display("FAIL error_pulse: got err %b dhit %b want 1 0", err, dhit);
        end
        next_cycle();
        drive_idle();
        @(negedge CLK);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL error_once: got err %b want 0", err);
        end
        next_cycle();
        iREN     = 1'b1;
        iaddr    = 32'h44;
        ramstate = RS_BUSY;
        next_cycle();
        iREN = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({ihit, err} !== 2'b00) begin
            n_fail++;
            $display("FAIL drop_quiet: got ihit/err %b want 00", {ihit, err});
        end
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (ramREN !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_idle: got ramREN %b want 0", ramREN);
        end
        drive_idle();
        next_cycle();
    endtask

    // Reset mid-fetch kills outputs at once; fetch restarts from IDLE.
    task automatic test_reset_mid();
        iREN     = 1'b1;
        iaddr    = 32'h80;
        ramstate = RS_BUSY;
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (ramREN !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got ramREN %b want 1", ramREN);
        end
        #2;
        nRST = 1'b0;
        #1;
        n_checks++;
        if ({ramREN, ihit, err} !== 3'b000 || ramaddr !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_kill: got ramREN/ihit/err %b addr %h want 000 0", {ramREN, ihit, err}, ramaddr);
        end
        @(negedge CLK);
        nRST     = 1'b1;
        ramstate = RS_ACCESS;
        ramload  = 32'hCAFE_0001;
        #1;
        n_checks++;
        if ({ramREN, ihit} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_idle: got ramREN/ihit %b want 00", {ramREN, ihit});
        end
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (ihit !== 1'b1 || ramaddr !== 32'h80 || iload !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL rstmid_refetch: got ihit %b addr %h iload %h want 1 00000080 cafe0001", ihit, ramaddr, iload);
        end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    // Halt during DATA: transaction finishes, then HALTED forever.
    task automatic test_halt();
        dREN     = 1'b1;
        daddr    = 32'h200;
        ramstate = RS_BUSY;
        next_cycle();
        halt = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({dhit, halted, ramREN} !== 3'b001) begin
            n_fail++;
            $display("FAIL halt_inflight: got dhit/halted/ramREN %b want 001", {dhit, halted, ramREN});
        end
        next_cycle();
        ramstate = RS_ACCESS;
        @(negedge CLK);
        n_checks++;
        if ({dhit, halted} !== 2'b10) begin
            n_fail++;
            $display("FAIL halt_complete: got dhit/halted %b want 10", {dhit, halted});
        end
        next_cycle();
        dREN = 1'b0;
        iREN = 1'b1;
        next_cycle();
        halt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            n_checks++;
            if ({halted, ihit, ramREN} !== 3'b100) begin
                n_fail++;
                $display("FAIL halt_sticky%0d: got halted/ihit/ramREN %b want 100", c, {halted, ihit, ramREN});
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_instr_fetch();
        test_data_priority();
        test_starvation();
        test_timeout();
        test_error_abort();
        test_reset_mid();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
